// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc_pkg
//  Description : Shared function codes, state encoding and function-class
//                decode for the handshaked multi-cycle ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

    // ALU_FUN codes
    localparam logic [3:0] FUN_ADD  = 4'd0;
    localparam logic [3:0] FUN_SUB  = 4'd1;
    localparam logic [3:0] FUN_MUL  = 4'd2;
    localparam logic [3:0] FUN_DIV  = 4'd3;
    localparam logic [3:0] FUN_AND  = 4'd4;
    localparam logic [3:0] FUN_OR   = 4'd5;
    localparam logic [3:0] FUN_NAND = 4'd6;
    localparam logic [3:0] FUN_NOR  = 4'd7;
    localparam logic [3:0] FUN_NOP  = 4'd8;
    localparam logic [3:0] FUN_EQ   = 4'd9;
    localparam logic [3:0] FUN_GT   = 4'd10;
    localparam logic [3:0] FUN_LT   = 4'd11;
    localparam logic [3:0] FUN_ASR  = 4'd12;
    localparam logic [3:0] FUN_LSL  = 4'd13;
    localparam logic [3:0] FUN_ROR  = 4'd14;
    localparam logic [3:0] FUN_ROL  = 4'd15;

    // Control state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DIV  = 1'b1;

    // Bit positions inside the one-hot class vector
    localparam int CLS_ARITH = 0;
    localparam int CLS_LOGIC = 1;
    localparam int CLS_CMP   = 2;
    localparam int CLS_SHIFT = 3;

    // The two upper code bits select the class group directly.
    function automatic logic [3:0] fun_class(input logic [1:0] grp);
        logic [3:0] cls;
        cls      = 4'b0000;
        cls[grp] = 1'b1;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_div_iter
//  Description : Iterative signed divider. Restoring division on operand
//                magnitudes, one quotient bit per cycle for WIDTH cycles,
//                signs applied on the final iteration. Flags divide-by-zero
//                (combinationally, from the live divisor) and the
//                most-negative / -1 overflow case.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_dbz,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_ovf
);

    localparam int               c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_running;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Magnitudes; the most-negative value maps onto itself, which is the
    // correct unsigned magnitude.
    assign w_a_mag = i_a[WIDTH-1] ? (-i_a) : i_a;
    assign w_b_mag = i_b[WIDTH-1] ? (-i_b) : i_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_fits    = ~w_trial[WIDTH];
    assign w_rem_nxt = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

    assign o_dbz  = (i_b == '0);
    assign o_done = r_running && (r_cnt == c_LAST);
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign o_quo  = r_neg_q ? (-w_quo_nxt) : w_quo_nxt;
    assign o_rem  = r_neg_r ? (-w_rem_nxt) : w_rem_nxt;
    assign o_ovf  = r_ovf;

    // Operand capture at start, then one iteration per cycle until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (i_start) begin
            r_running <= 1'b1;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_a_mag;
            r_dvs     <= w_b_mag;
            r_neg_q   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_neg_r   <= i_a[WIDTH-1];
            r_ovf     <= (i_a == c_MIN) && (i_b == '1);
        end else if (r_running) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + c_CW'(1);
            if (o_done) begin
                r_running <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc_core
//  Description : Handshaked 16-function ALU with a single-entry output
//                register. Single-cycle functions load the output at the
//                acceptance edge; signed divide runs WIDTH cycles in the
//                iterative divider while the block reports BUSY.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc_core #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   RESULT,
    output logic                 CARRY_OUT,
    output logic                 OVF,
    output logic                 DIV_BY_ZERO,
    output logic                 ARITH_FLAG,
    output logic                 LOGIC_FLAG,
    output logic                 CMP_FLAG,
    output logic                 SHIFT_FLAG,
    output logic                 BUSY
);

    import alu_mc_pkg::*;

    localparam int c_W2 = 2 * WIDTH;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   r_out_valid;
    logic [c_W2-1:0]        r_result;
    logic                   r_carry;
    logic                   r_ovf;
    logic                   r_dbz;
    logic [3:0]             r_class;

    logic                   w_accept;
    logic                   w_div_start;
    logic                   w_div_dbz;
    logic                   w_div_done;
    logic [WIDTH-1:0]       w_div_quo;
    logic [WIDTH-1:0]       w_div_rem;
    logic                   w_div_ovf;

    logic signed [WIDTH:0]  w_sum;
    logic signed [WIDTH:0]  w_diff;
    logic signed [c_W2-1:0] w_a_ext;
    logic signed [c_W2-1:0] w_b_ext;
    logic signed [c_W2-1:0] w_prod;
    logic [SHW-1:0]         w_amt;
    logic [WIDTH-1:0]       w_asr;
    logic [WIDTH-1:0]       w_lsl;
    logic [WIDTH-1:0]       w_ror;
    logic [WIDTH-1:0]       w_rol;

    logic [c_W2-1:0]        w_res;
    logic                   w_cy;
    logic                   w_ov;
    logic                   w_dz;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign IN_READY    = !RST && (r_state == IDLE) && (!r_out_valid || OUT_READY);
    assign w_accept    = IN_VALID && IN_READY;
    // Divide by zero bypasses the divider and completes in one cycle.
    assign w_div_start = w_accept && (ALU_FUN == FUN_DIV) && !w_div_dbz;

    assign OUT_VALID   = r_out_valid;
    assign RESULT      = r_result;
    assign CARRY_OUT   = r_carry;
    assign OVF         = r_ovf;
    assign DIV_BY_ZERO = r_dbz;
    assign ARITH_FLAG  = r_class[CLS_ARITH];
    assign LOGIC_FLAG  = r_class[CLS_LOGIC];
    assign CMP_FLAG    = r_class[CLS_CMP];
    assign SHIFT_FLAG  = r_class[CLS_SHIFT];
    assign BUSY        = (r_state == DIV);

    alu_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk     (CLK),
        .rst     (RST),
        .i_start (w_div_start),
        .i_a     (A),
        .i_b     (B),
        .o_dbz   (w_div_dbz),
        .o_done  (w_div_done),
        .o_quo   (w_div_quo),
        .o_rem   (w_div_rem),
        .o_ovf   (w_div_ovf)
    );

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_sum   = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    assign w_diff  = {A[WIDTH-1], A} - {B[WIDTH-1], B};
    assign w_a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign w_b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_amt   = B[SHW-1:0];
    assign w_asr   = $signed(A) >>> w_amt;
    assign w_lsl   = A << w_amt;
    // A shift by WIDTH yields zero, so amount 0 rotates to A unchanged.
    assign w_ror   = (A >> w_amt) | (A << (WIDTH - int'(w_amt)));
    assign w_rol   = (A << w_amt) | (A >> (WIDTH - int'(w_amt)));

    // Result and flag selection for every function that finishes in one cycle.
    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        w_dz  = 1'b0;
        case (ALU_FUN)
            FUN_ADD: begin
                w_res = {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
                // Carry into the sign-extension bit is the unsigned carry out.
                w_cy  = w_sum[WIDTH] ^ A[WIDTH-1] ^ B[WIDTH-1];
                w_ov  = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            FUN_SUB: begin
                w_res = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
                w_cy  = (A < B);
                w_ov  = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            FUN_MUL:  w_res = w_prod;
            FUN_DIV: begin
                w_res = {A, {WIDTH{1'b1}}};
                w_dz  = 1'b1;
            end
            FUN_AND:  w_res = {{WIDTH{1'b0}}, A & B};
            FUN_OR:   w_res = {{WIDTH{1'b0}}, A | B};
            FUN_NAND: w_res = {{WIDTH{1'b0}}, ~(A & B)};
            FUN_NOR:  w_res = {{WIDTH{1'b0}}, ~(A | B)};
            FUN_NOP:  w_res = '0;
            FUN_EQ:   w_res = {{(c_W2-1){1'b0}}, (A == B)};
            FUN_GT:   w_res = {{(c_W2-1){1'b0}}, ($signed(A) > $signed(B))};
            FUN_LT:   w_res = {{(c_W2-1){1'b0}}, ($signed(A) < $signed(B))};
            FUN_ASR:  w_res = {{WIDTH{1'b0}}, w_asr};
            FUN_LSL:  w_res = {{WIDTH{1'b0}}, w_lsl};
            FUN_ROR:  w_res = {{WIDTH{1'b0}}, w_ror};
            FUN_ROL:  w_res = {{WIDTH{1'b0}}, w_rol};
            default:  w_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enter DIV on a real divide, leave when the divider finishes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_div_start) w_state_nxt = DIV;
            DIV:     if (w_div_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output register: load on divide completion or single-cycle acceptance,
    // otherwise hold, dropping valid once the consumer has taken it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_class     <= 4'b0000;
        end else if (w_div_done) begin
            r_out_valid <= 1'b1;
            r_result    <= {w_div_rem, w_div_quo};
            r_carry     <= 1'b0;
            r_ovf       <= w_div_ovf;
            r_dbz       <= 1'b0;
            r_class     <= fun_class(FUN_DIV[3:2]);
        end else if (w_accept && !w_div_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_carry     <= w_cy;
            r_ovf       <= w_ov;
            r_dbz       <= w_dz;
            r_class     <= fun_class(ALU_FUN[3:2]);
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc_core
//  Description : Self-checking bench for alu_mc_core (WIDTH=16) with a
//                behavioural integer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc_core;

    localparam int W = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUN = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] RESULT;
    logic        CARRY_OUT, OVF, DIV_BY_ZERO;
    logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, BUSY;

    int checks = 0;
    int errors = 0;

    alu_mc_core #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .CARRY_OUT(CARRY_OUT), .OVF(OVF), .DIV_BY_ZERO(DIV_BY_ZERO),
        .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG),
        .SHIFT_FLAG(SHIFT_FLAG), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference model: integer arithmetic on the operand values.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] f, output logic [31:0] r,
                                      output logic cy, output logic ov, output logic dz);
        longint sa, sb, t, q, m;
        int amt;
        logic [15:0] x;
        logic [16:0] us;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(b[3:0]);
        r = '0; cy = 1'b0; ov = 1'b0; dz = 1'b0;
        case (f)
            4'd0: begin
                t = sa + sb; r = t[31:0];
                us = {1'b0, a} + {1'b0, b}; cy = us[16];
                ov = (t > 32767) || (t < -32768);
            end
            4'd1: begin
                t = sa - sb; r = t[31:0];
                cy = (a < b);
                ov = (t > 32767) || (t < -32768);
            end
            4'd2: begin t = sa * sb; r = t[31:0]; end
            4'd3: begin
                if (b == 16'h0) begin
                    r = {a, 16'hFFFF}; dz = 1'b1;
                end else if (sa == -32768 && sb == -1) begin
                    r = 32'h0000_8000; ov = 1'b1;
                end else begin
                    q = sa / sb; m = sa % sb;
                    r = {m[15:0], q[15:0]};
                end
            end
            4'd4: r = {16'h0, a & b};
            4'd5: r = {16'h0, a | b};
            4'd6: r = {16'h0, ~(a & b)};
            4'd7: r = {16'h0, ~(a | b)};
            4'd8: r = '0;
            4'd9:  r = (a == b) ? 32'd1 : 32'd0;
            4'd10: r = (sa > sb) ? 32'd1 : 32'd0;
            4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: begin t = sa >>> amt; r = {16'h0, t[15:0]}; end
            4'd13: begin x = a << amt; r = {16'h0, x}; end
            4'd14: begin x = a; repeat (amt) x = {x[0], x[15:1]}; r = {16'h0, x}; end
            default: begin x = a; repeat (amt) x = {x[14:0], x[15]}; r = {16'h0, x}; end
        endcase
    endfunction

    // Issue one operation with OUT_READY as currently set and wait (bounded)
    // for its result. n = edges after acceptance until OUT_VALID.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                          output logic acc, output logic [31:0] res, output logic cy,
                          output logic ov, output logic dz, output logic [3:0] cls,
                          output int n, output int busy_n);
        IN_VALID = 1'b1; A = a; B = b; ALU_FUN = f;
        @(negedge CLK);
        acc = IN_READY;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = 16'($urandom); B = 16'($urandom); ALU_FUN = 4'($urandom);
        n = 0; busy_n = 0;
        while (OUT_VALID !== 1'b1 && n < 40) begin
            if (BUSY === 1'b1 && IN_READY === 1'b0) busy_n++;
            @(posedge CLK); #1;
            n++;
        end
        res = RESULT; cy = CARRY_OUT; ov = OVF; dz = DIV_BY_ZERO;
        cls = {SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG};
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || RESULT !== 32'h0) begin
            errors++; $display("FAIL reset_out: valid=%b busy=%b result=%h required 0 0 0", OUT_VALID, BUSY, RESULT);
        end
        checks++;
        if ({CARRY_OUT, OVF, DIV_BY_ZERO, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 0000000",
                {CARRY_OUT, OVF, DIV_BY_ZERO, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG});
        end
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b required 0", IN_READY);
        end
        @(posedge CLK); #1;
        RST = 1'b0; #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready: got %b required 1", IN_READY);
        end
    endtask

    localparam int ND = 11;
    logic [15:0] d_a   [ND] = '{16'hFFEE, 16'hFFFB, 16'h7FFF, 16'hFFC7, 16'h0019, 16'h8000,
                                16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h005E};
    logic [15:0] d_b   [ND] = '{16'hFFCE, 16'hFFC9, 16'h0001, 16'h0005, 16'h0000, 16'hFFFF,
                                16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h001E};
    logic [3:0]  d_f   [ND] = '{4'd0, 4'd2, 4'd0, 4'd3, 4'd3, 4'd3, 4'd15, 4'd14, 4'd12, 4'd13, 4'd10};
    logic [31:0] d_r   [ND] = '{32'hFFFFFFBC, 32'h00000113, 32'h00008000, 32'hFFFEFFF5, 32'h0019FFFF,
                                32'h00008000, 32'h00000018, 32'h00001800, 32'h0000F800,
                                32'h00000010, 32'h00000001};
    logic [2:0]  d_fl  [ND] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b010,
                                3'b000, 3'b000, 3'b000, 3'b000, 3'b000}; // {carry,ovf,dbz}
    int          d_lat [ND] = '{0, 0, 0, 16, 0, 16, 0, 0, 0, 0, 0};

    task automatic test_directed();
        logic acc, cy, ov, dz; logic [31:0] res; logic [3:0] cls, ecls; int n, bn;
        OUT_READY = 1'b1;
        for (int i = 0; i < ND; i++) begin
            run_op(d_a[i], d_b[i], d_f[i], acc, res, cy, ov, dz, cls, n, bn);
            ecls = 4'b0001 << d_f[i][3:2];
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept: got %b required 1", i, acc); end
            checks++;
            if (res !== d_r[i]) begin errors++; $display("FAIL dir%0d_result: got %h required %h", i, res, d_r[i]); end
            checks++;
            if ({cy, ov, dz} !== d_fl[i]) begin errors++; $display("FAIL dir%0d_flags: got %b required %b", i, {cy, ov, dz}, d_fl[i]); end
            checks++;
            if (cls !== ecls) begin errors++; $display("FAIL dir%0d_class: got %b required %b", i, cls, ecls); end
            checks++;
            if (n !== d_lat[i]) begin errors++; $display("FAIL dir%0d_latency: got %0d required %0d", i, n, d_lat[i]); end
            checks++;
            if (bn !== d_lat[i]) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d required %0d", i, bn, d_lat[i]); end
        end
    endtask

    task automatic test_random();
        logic acc, cy, ov, dz, ecy, eov, edz; logic [31:0] res, er; logic [3:0] cls, ecls, f;
        logic [15:0] a, b; int n, bn, elat;
        logic [15:0] corner [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        OUT_READY = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 4)];
            run_op(a, b, f, acc, res, cy, ov, dz, cls, n, bn);
            ref_model(a, b, f, er, ecy, eov, edz);
            ecls = 4'b0001 << f[3:2];
            elat = (f == 4'd3 && b != 16'h0) ? 16 : 0;
            checks++;
            if (acc !== 1'b1 || n !== elat) begin
                errors++; $display("FAIL rnd%0d_timing: accept=%b latency=%0d required 1 %0d", i, acc, n, elat);
            end
            checks++;
            if (res !== er || {cy, ov, dz} !== {ecy, eov, edz} || cls !== ecls) begin
                errors++;
                $display("FAIL rnd%0d_op: f=%0d a=%h b=%h got %h/%b/%b required %h/%b/%b",
                    i, f, a, b, res, {cy, ov, dz}, cls, er, {ecy, eov, edz}, ecls);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b; logic [3:0] f; logic [31:0] er; logic ecy, eov, edz;
        OUT_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            do f = 4'($urandom); while (f == 4'd3);
            IN_VALID = 1'b1; A = a; B = b; ALU_FUN = f;
            @(negedge CLK);
            checks++;
            if (IN_READY !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready: got %b required 1", i, IN_READY); end
            @(posedge CLK); #1;
            ref_model(a, b, f, er, ecy, eov, edz);
            checks++;
            if (OUT_VALID !== 1'b1 || RESULT !== er || {CARRY_OUT, OVF} !== {ecy, eov}) begin
                errors++;
                $display("FAIL b2b%0d_result: valid=%b got %h/%b required 1 %h/%b",
                    i, OUT_VALID, RESULT, {CARRY_OUT, OVF}, er, {ecy, eov});
            end
        end
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%b required 0", OUT_VALID); end
    endtask

    task automatic test_backpressure();
        logic acc, cy, ov, dz; logic [31:0] res, er; logic [3:0] cls; int n, bn;
        logic ecy, eov, edz;
        OUT_READY = 1'b0;
        run_op(16'h1234, 16'h0F0F, 4'd4, acc, res, cy, ov, dz, cls, n, bn);
        checks++;
        if (res !== 32'h0000_0204 || n !== 0) begin
            errors++; $display("FAIL bp_first: got %h lat %0d required 00000204 lat 0", res, n);
        end
        IN_VALID = 1'b1; A = 16'h7FFF; B = 16'h0001; ALU_FUN = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready: got %b required 0", i, IN_READY); end
            @(posedge CLK); #1;
            checks++;
            if (OUT_VALID !== 1'b1 || RESULT !== 32'h0000_0204 || LOGIC_FLAG !== 1'b1 || ARITH_FLAG !== 1'b0) begin
                errors++;
                $display("FAIL bp%0d_hold: valid=%b result=%h logic=%b arith=%b required 1 00000204 1 0",
                    i, OUT_VALID, RESULT, LOGIC_FLAG, ARITH_FLAG);
            end
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (IN_READY !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b required 1", IN_READY); end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        ref_model(16'h7FFF, 16'h0001, 4'd0, er, ecy, eov, edz);
        checks++;
        if (OUT_VALID !== 1'b1 || RESULT !== er || OVF !== eov || ARITH_FLAG !== 1'b1) begin
            errors++; $display("FAIL bp_reload: valid=%b got %h ovf %b required 1 %h ovf %b", OUT_VALID, RESULT, OVF, er, eov);
        end
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_drop: valid=%b required 0", OUT_VALID); end
    endtask

    task automatic test_reset_mid_div();
        int stale;
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; A = 16'hFFC7; B = 16'h0005; ALU_FUN = 4'd3;
        @(negedge CLK);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL rstdiv_busy_before: got %b required 1", BUSY); end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (IN_READY !== 1'b0) begin errors++; $display("FAIL rstdiv_in_ready: got %b required 0", IN_READY); end
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL rstdiv_abort: valid=%b busy=%b required 0 0", OUT_VALID, BUSY);
        end
        RST = 1'b0;
        stale = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge CLK); #1;
            if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin errors++; $display("FAIL rstdiv_stale: got %0d cycles with activity required 0", stale); end
        checks++;
        if (IN_READY !== 1'b1) begin errors++; $display("FAIL rstdiv_ready_after: got %b required 1", IN_READY); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
